// File: rtl/pc_desvio_seq.sv
// rtl/pc_desvio_seq.sv - sequential program counter with branch resolution and fetch handshake
//
// Purpose: owns the PC register. It resolves branches and jumps (signed and
// unsigned compares, jal, jalr) and produces the link address. It handshakes
// with instruction fetch and keeps a resolved redirect while fetch is busy.
//
// Ports:
//   clk, rst_n        clock; synchronous active-low reset
//   stall             pipeline held: branch inputs ignored, PC frozen
//   PCSrc             current instruction is a branch/jump
//   Tipo_Branch[3:0]  branch/jump kind
//   imed, ULA_res     offset/absolute target, jalr target
//   neg, zero, carry  ULA compare flags (carry = unsigned rs1 < rs2)
//   fetch_ack         fetch accepted the PC this cycle
//   PC                current PC (registered)
//   fetch_req         PC valid for fetch
//   link              PC + PC_INC, return address
//   taken             resolved branch taken this cycle (combinational)
//   flush             one-cycle pulse after a taken redirect is applied
//   taken_count       saturating count of applied taken redirects
module pc_desvio_seq #(
    parameter int              XLEN     = 32,
    parameter int              PC_INC   = 1,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int              CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stall,
    input  logic             PCSrc,
    input  logic [3:0]       Tipo_Branch,
    input  logic [XLEN-1:0]  imed,
    input  logic [XLEN-1:0]  ULA_res,
    input  logic             neg,
    input  logic             zero,
    input  logic             carry,
    input  logic             fetch_ack,
    output logic [XLEN-1:0]  PC,
    output logic             fetch_req,
    output logic [XLEN-1:0]  link,
    output logic             taken,
    output logic             flush,
    output logic [CNT_W-1:0] taken_count
);

    localparam logic [XLEN-1:0] INC = XLEN'(PC_INC);

    typedef enum logic [1:0] {
        ST_BOOT,
        ST_RUN,
        ST_REDIR
    } state_t;

    state_t            state_q, state_d;
    logic [XLEN-1:0]   pc_q, pc_d;
    logic [XLEN-1:0]   redir_q, redir_d;
    logic              flush_q, flush_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic              cond;
    logic [XLEN-1:0]   target;
    logic [XLEN-1:0]   seq_pc;
    logic [CNT_W-1:0]  cnt_sat_inc;
    logic              resolve;

    // Branch condition and target decode; unused codes act as an unconditional
    // relative jump.
    always_comb begin
        cond = 1'b1;
        case (Tipo_Branch)
            4'd1:    cond = zero;
            4'd2:    cond = !zero;
            4'd3:    cond = neg;
            4'd4:    cond = !neg;
            4'd5:    cond = carry;
            4'd8:    cond = !carry;
            default: cond = 1'b1;
        endcase
    end

    always_comb begin
        target = pc_q + imed;
        case (Tipo_Branch)
            4'd6:    target = imed;
            4'd7:    target = ULA_res;
            default: target = pc_q + imed;
        endcase
    end

    assign seq_pc      = pc_q + INC;
    assign resolve     = (state_q == ST_RUN) && !stall;
    assign cnt_sat_inc = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);

    assign PC          = pc_q;
    assign link        = seq_pc;
    assign taken       = resolve && PCSrc && cond;
    assign fetch_req   = (state_q != ST_BOOT);
    assign flush       = flush_q;
    assign taken_count = cnt_q;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        redir_d = redir_q;
        flush_d = 1'b0;
        cnt_d   = cnt_q;
        case (state_q)
            ST_BOOT: begin
                state_d = ST_RUN;
            end
            ST_RUN: begin
                if (resolve) begin
                    if (fetch_ack) begin
                        if (taken) begin
                            pc_d    = target;
                            flush_d = 1'b1;
                            cnt_d   = cnt_sat_inc;
                        end else begin
                            pc_d = seq_pc;
                        end
                    end else if (taken) begin
                        // Fetch is busy: park the target so later input changes
                        // cannot alter it.
                        redir_d = target;
                        state_d = ST_REDIR;
                    end
                end
            end
            ST_REDIR: begin
                if (fetch_ack && !stall) begin
                    pc_d    = redir_q;
                    state_d = ST_RUN;
                    flush_d = 1'b1;
                    cnt_d   = cnt_sat_inc;
                end
            end
            default: begin
                state_d = ST_BOOT;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_BOOT;
            pc_q    <= RESET_PC;
            redir_q <= '0;
            flush_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            redir_q <= redir_d;
            flush_q <= flush_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule
